// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- central pipeline sequencer for the 5-stage core.
//
// Merges per-stage stall requests, multi-cycle EX operations and
// exception/redirect flushes into one stall vector and one flush strobe.
// stall/flush/new_pc are combinational so they act in the same cycle;
// multi-cycle sequencing lives in a two-state FSM plus a down-counter.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stallreq_if     fetch not ready (level)
//   stallreq_id     load-use hazard (level)
//   stallreq_ex     EX single-extra-cycle stall (level)
//   stallreq_mem    data memory not ready (level)
//   mcyc_start      pulse: EX begins a multi-cycle op
//   mcyc_len        total stall cycles for that op
//   flush_req       exception/redirect from MEM (level)
//   flush_pc        handler/redirect address
//   stall[5:0]      bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
//   flush           clear all inter-stage registers this cycle
//   new_pc          PC to load when flush=1 (0 otherwise)
//   mcyc_busy       FSM in MCYC state
//   mcyc_done       one-cycle pulse after a multi-cycle op completes
//   stall_cnt       cycles with stall!=0 (PIPE_CTRL_PERF_EN only, else 0)
//   flush_cnt       number of flushes    (PIPE_CTRL_PERF_EN only, else 0)
//
// Optional feature macro: PIPE_CTRL_PERF_EN enables the saturating
// performance counters; when undefined no counter registers are built.

module pipe_ctrl #(
  parameter int MCYC_W = 6,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              mcyc_start,
  input  logic [MCYC_W-1:0] mcyc_len,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              mcyc_busy,
  output logic              mcyc_done,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_MCYC = 1'b1;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  logic [0:0]        state_q, state_d;
  logic [MCYC_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              ex_hold_s;
  logic [5:0]        stall_s;
  logic              flush_s;
  logic [31:0]       new_pc_s;

  // Multi-cycle FSM next state; a flush aborts any op without a done pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    ex_hold_s = 1'b0;
    if (flush_req) begin
      state_d = ST_RUN;
      cnt_d   = {MCYC_W{1'b0}};
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mcyc_start && (mcyc_len != {MCYC_W{1'b0}})) begin
            ex_hold_s = 1'b1;
            if (mcyc_len == MCYC_W'(1'b1)) begin
              done_d = 1'b1;
            end else begin
              // This cycle already counts as the first stall, and the
              // counter==0 cycle stalls too, hence the -2.
              state_d = ST_MCYC;
              cnt_d   = mcyc_len - MCYC_W'(2'd2);
            end
          end else begin
            ex_hold_s = 1'b0;
          end
        end
        ST_MCYC: begin
          // Any mcyc_start here is ignored: EX is frozen.
          ex_hold_s = 1'b1;
          if (cnt_q != {MCYC_W{1'b0}}) begin
            cnt_d = cnt_q - MCYC_W'(1'b1);
          end else begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = {MCYC_W{1'b0}};
        end
      endcase
    end
  end

  // Stall/flush priority resolution: flush, mem, ex/mcyc, id, if.
  always_comb begin
    stall_s  = STALL_NONE;
    flush_s  = 1'b0;
    new_pc_s = 32'h0000_0000;
    if (rst) begin
      stall_s  = STALL_NONE;
      flush_s  = 1'b0;
      new_pc_s = 32'h0000_0000;
    end else if (flush_req) begin
      flush_s  = 1'b1;
      new_pc_s = flush_pc;
    end else if (stallreq_mem) begin
      stall_s = STALL_MEM;
    end else if (ex_hold_s || stallreq_ex) begin
      stall_s = STALL_EX;
    end else if (stallreq_id) begin
      stall_s = STALL_ID;
    end else if (stallreq_if) begin
      stall_s = STALL_IF;
    end else begin
      stall_s = STALL_NONE;
    end
  end

  // FSM, counter and done-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= {MCYC_W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign stall     = stall_s;
  assign flush     = flush_s;
  assign new_pc    = new_pc_s;
  assign mcyc_busy = (state_q == ST_MCYC);
  assign mcyc_done = done_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters; stall_s/flush_s are already 0 during rst.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((stall_s != STALL_NONE) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl.
// Each step drives inputs just after a rising edge, pushes the expected
// {stall, flush, new_pc, mcyc_busy, mcyc_done} into a scoreboard queue,
// and pops/compares it on the following falling edge.

`timescale 1ns/1ps

module tb_pipe_ctrl;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_IF   = 6'b000011;
  localparam logic [5:0] S_ID   = 6'b000111;
  localparam logic [5:0] S_EX   = 6'b001111;
  localparam logic [5:0] S_MEM  = 6'b011111;

  // Request vector order: {mem, ex, id, if}
  localparam logic [3:0] R_NONE = 4'b0000;
  localparam logic [3:0] R_IF   = 4'b0001;
  localparam logic [3:0] R_ID   = 4'b0010;
  localparam logic [3:0] R_EX   = 4'b0100;
  localparam logic [3:0] R_MEM  = 4'b1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        mcyc_start;
  logic [5:0]  mcyc_len;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mcyc_busy, mcyc_done;
  logic [31:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [40:0] sb[$];
  logic [40:0] obs;
  assign obs = {stall, flush, new_pc, mcyc_busy, mcyc_done};

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic        start;
    logic [5:0]  len;
    logic        fr;
    logic [31:0] fpc;
    logic        chk;
    logic [40:0] exp;
  } step_t;

  pipe_ctrl #(.MCYC_W(6), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .mcyc_start(mcyc_start), .mcyc_len(mcyc_len),
    .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .mcyc_busy(mcyc_busy), .mcyc_done(mcyc_done),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [40:0] e(input logic [5:0] s, input logic f,
                                    input logic [31:0] p, input logic b, input logic d);
    return {s, f, p, b, d};
  endfunction

  function automatic step_t st(input logic r, input logic [3:0] q, input logic s,
                               input logic [5:0] l, input logic f, input logic [31:0] p,
                               input logic c, input logic [40:0] x);
    step_t t;
    t.rst = r; t.req = q; t.start = s; t.len = l; t.fr = f; t.fpc = p; t.chk = c; t.exp = x;
    return t;
  endfunction

  task automatic drive(input step_t s);
    rst = s.rst;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = s.req;
    mcyc_start = s.start;
    mcyc_len   = s.len;
    flush_req  = s.fr;
    flush_pc   = s.fpc;
    if (s.chk) sb.push_back(s.exp);
  endtask

  task automatic test_reset();
    step_t t[$];
    logic [40:0] want;
    t.push_back(st(1'b1, 4'b1111, 1'b1, 6'd5, 1'b1, 32'hDEAD_BEEF, 1'b1, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b0)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b0)));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      if (t[i].chk) begin
        want = sb.pop_front(); n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL reset step %0d: got %h expected %h", i, obs, want); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_id_stall();
    step_t t[$];
    logic [40:0] want;
    t.push_back(st(1'b0, R_ID, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_ID, 1'b0, 32'h0, 1'b0, 1'b0)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b0)));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      if (t[i].chk) begin
        want = sb.pop_front(); n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL id_stall step %0d: got %h expected %h", i, obs, want); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multicycle();
    step_t t[$];
    logic [40:0] want;
    t.push_back(st(1'b0, R_NONE, 1'b1, 6'd5, 1'b0, 32'h0, 1'b1, e(S_EX, 1'b0, 32'h0, 1'b0, 1'b0)));
    for (int k = 0; k < 4; k++)
      t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_EX, 1'b0, 32'h0, 1'b1, 1'b0)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b1)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b0)));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      if (t[i].chk) begin
        want = sb.pop_front(); n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL multicycle5 step %0d: got %h expected %h", i, obs, want); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush_abort();
    step_t t[$];
    logic [40:0] want;
    t.push_back(st(1'b0, R_NONE, 1'b1, 6'd3, 1'b0, 32'h0, 1'b1, e(S_EX, 1'b0, 32'h0, 1'b0, 1'b0)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b1, 32'h0000_0020, 1'b1, e(S_NONE, 1'b1, 32'h0000_0020, 1'b1, 1'b0)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0000_0020, 1'b1, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b0)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b0)));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      if (t[i].chk) begin
        want = sb.pop_front(); n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL flush_abort step %0d: got %h expected %h", i, obs, want); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    step_t t[$];
    logic [40:0] want;
    t.push_back(st(1'b0, R_MEM | R_ID | R_IF, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_MEM, 1'b0, 32'h0, 1'b0, 1'b0)));
    t.push_back(st(1'b0, R_ID | R_IF, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_ID, 1'b0, 32'h0, 1'b0, 1'b0)));
    t.push_back(st(1'b0, R_IF, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_IF, 1'b0, 32'h0, 1'b0, 1'b0)));
    t.push_back(st(1'b0, R_EX, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_EX, 1'b0, 32'h0, 1'b0, 1'b0)));
    t.push_back(st(1'b0, R_EX | R_ID | R_IF, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_EX, 1'b0, 32'h0, 1'b0, 1'b0)));
    t.push_back(st(1'b0, 4'b1111, 1'b0, 6'd0, 1'b1, 32'h0000_1234, 1'b1, e(S_NONE, 1'b1, 32'h0000_1234, 1'b0, 1'b0)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0000_1234, 1'b1, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b0)));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      if (t[i].chk) begin
        want = sb.pop_front(); n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL priority step %0d: got %h expected %h", i, obs, want); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_len_edges();
    step_t t[$];
    logic [40:0] want;
    t.push_back(st(1'b0, R_NONE, 1'b1, 6'd0, 1'b0, 32'h0, 1'b1, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b0)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b0)));
    t.push_back(st(1'b0, R_NONE, 1'b1, 6'd1, 1'b0, 32'h0, 1'b1, e(S_EX, 1'b0, 32'h0, 1'b0, 1'b0)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b1)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b0)));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      if (t[i].chk) begin
        want = sb.pop_front(); n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL len_edges step %0d: got %h expected %h", i, obs, want); end
      end
      @(posedge clk); #1;
    end
  endtask

  // Restart while busy is ignored; mem stall during MCYC widens the vector
  // but the op still completes after exactly mcyc_len stalled cycles.
  task automatic test_mcyc_ignore_mem();
    step_t t[$];
    logic [40:0] want;
    t.push_back(st(1'b0, R_NONE, 1'b1, 6'd3, 1'b0, 32'h0, 1'b1, e(S_EX, 1'b0, 32'h0, 1'b0, 1'b0)));
    t.push_back(st(1'b0, R_MEM, 1'b1, 6'd6, 1'b0, 32'h0, 1'b1, e(S_MEM, 1'b0, 32'h0, 1'b1, 1'b0)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_EX, 1'b0, 32'h0, 1'b1, 1'b0)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b1)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b0)));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      if (t[i].chk) begin
        want = sb.pop_front(); n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL mcyc_ignore_mem step %0d: got %h expected %h", i, obs, want); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush_vs_start();
    step_t t[$];
    logic [40:0] want;
    t.push_back(st(1'b0, R_NONE, 1'b1, 6'd4, 1'b1, 32'h0000_0040, 1'b1, e(S_NONE, 1'b1, 32'h0000_0040, 1'b0, 1'b0)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b0)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b0)));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      if (t[i].chk) begin
        want = sb.pop_front(); n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL flush_vs_start step %0d: got %h expected %h", i, obs, want); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_mcyc();
    step_t t[$];
    logic [40:0] want;
    t.push_back(st(1'b0, R_NONE, 1'b1, 6'd5, 1'b0, 32'h0, 1'b1, e(S_EX, 1'b0, 32'h0, 1'b0, 1'b0)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_EX, 1'b0, 32'h0, 1'b1, 1'b0)));
    t.push_back(st(1'b1, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b0)));
    for (int k = 0; k < 5; k++)
      t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b0)));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      if (t[i].chk) begin
        want = sb.pop_front(); n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL reset_mid_mcyc step %0d: got %h expected %h", i, obs, want); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_perf();
    step_t t[$];
    logic [40:0] want;
    t.push_back(st(1'b1, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b0)));
    t.push_back(st(1'b0, R_NONE, 1'b1, 6'd5, 1'b0, 32'h0, 1'b1, e(S_EX, 1'b0, 32'h0, 1'b0, 1'b0)));
    for (int k = 0; k < 4; k++)
      t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_EX, 1'b0, 32'h0, 1'b1, 1'b0)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b1)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b1, 32'h0000_0080, 1'b1, e(S_NONE, 1'b1, 32'h0000_0080, 1'b0, 1'b0)));
    t.push_back(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b0)));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      if (t[i].chk) begin
        want = sb.pop_front(); n_cmp++;
        if (obs !== want) begin n_err++; $display("FAIL perf_seq step %0d: got %h expected %h", i, obs, want); end
      end
      @(posedge clk); #1;
    end
`ifdef PIPE_CTRL_PERF_EN
    n_cmp++;
    if (stall_cnt !== 32'd5) begin n_err++; $display("FAIL perf_stall_cnt: got %0d expected 5", stall_cnt); end
    n_cmp++;
    if (flush_cnt !== 32'd1) begin n_err++; $display("FAIL perf_flush_cnt: got %0d expected 1", flush_cnt); end
    drive(st(1'b1, R_ID, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b0)));
    @(posedge clk); #1;
    n_cmp++;
    if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL perf_stall_cnt_rst: got %0d expected 0", stall_cnt); end
    n_cmp++;
    if (flush_cnt !== 32'd0) begin n_err++; $display("FAIL perf_flush_cnt_rst: got %0d expected 0", flush_cnt); end
    drive(st(1'b0, R_NONE, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0, e(S_NONE, 1'b0, 32'h0, 1'b0, 1'b0)));
    @(posedge clk); #1;
`else
    n_cmp++;
    if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL perf_off_stall_cnt: got %0d expected 0", stall_cnt); end
    n_cmp++;
    if (flush_cnt !== 32'd0) begin n_err++; $display("FAIL perf_off_flush_cnt: got %0d expected 0", flush_cnt); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0000;
    mcyc_start = 1'b0;
    mcyc_len   = 6'd0;
    flush_req  = 1'b0;
    flush_pc   = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_id_stall();
    test_multicycle();
    test_flush_abort();
    test_priority();
    test_len_edges();
    test_mcyc_ignore_mem();
    test_flush_vs_start();
    test_reset_mid_mcyc();
    test_perf();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
